boot_loader: RTL
================

# boot_loader

Program loader between an external byte source and the 256x16 instruction/data SRAM. While the core is held in reset, it receives a length-prefixed byte stream, packs byte pairs into 16-bit words and writes them to consecutive SRAM addresses from 0. When the image is complete it releases the core reset so fetch starts at IP = 0. It drives the SRAM port through the address/data bus muxes during load only.

## Interface
Parameters:
- none

Ports:
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; clears loader and re-arms load
- in_data  in  [0:7]  byte from source; bit 0 = MSB
- in_valid  in  1  in_data valid this cycle
- in_ready  out  1  loader accepts byte this cycle; transfer = in_valid & in_ready at rising edge
- mem_addr  out  [0:7]  SRAM address during load
- mem_data  out  [0:15]  SRAM write data; bit 0 = MSB
- mem_csb  out  1  SRAM chip select, active-low
- mem_web  out  1  SRAM write enable, active-low
- core_reset  out  1  held high until load completes; drives core internal reset
- done  out  1  image loaded, core running
- error  out  1  load failed (checksum builds only; else tied 0)

## Operation
- Stream format: count byte C, then 2*N data bytes, high byte first per word; N = C, except C = 0 means N = 256.
- States: COUNT, HI, LO, WRITE, CSUM (macro builds only), DONE, ERR.
- COUNT: in_ready = 1; on transfer, load 9-bit remaining = N, addr = 0, go HI.
- HI: in_ready = 1; on transfer, latch byte into mem_data[0:7], go LO.
- LO: in_ready = 1; on transfer, latch byte into mem_data[8:15], go WRITE.
- WRITE: in_ready = 0; mem_csb = 0, mem_web = 0 for exactly this cycle; at edge addr += 1 (8-bit wrap 255 -> 0 only after last write), remaining -= 1; if remaining becomes 0 go CSUM or DONE, else HI.
- DONE: in_ready = 0, core_reset = 0, done = 1; sticky until reset; further bytes ignored (not accepted).
- ERR: in_ready = 0, core_reset = 1, error = 1; sticky until reset.
- mem_csb = mem_web = 1 in every state except WRITE.
- Word i of the image lands at address i; mem_addr holds last written address + 1 after each write.

## Timing
- Reset values: state COUNT, in_ready = 1 (combinational from state), mem_addr = 0, mem_data = 0, mem_csb = 1, mem_web = 1, core_reset = 1, done = 0, error = 0.
- Reset asserted mid-load: next cycle equals reset values; partially written SRAM contents are not cleared; core stays in reset.
- Latency: transfer of low byte at edge k -> WRITE during cycle k+1 -> HI at k+2. Peak rate 2 bytes per 3 cycles.
- in_valid low in any accepting state: state and outputs hold.
- Final WRITE at edge k -> done = 1 and core_reset = 0 from cycle k+1 (no CSUM).
- in_ready is a function of state only; it never depends on in_valid.

## Configuration
- BOOT_CHECKSUM_EN defined: stream carries one trailing checksum byte after the last data byte. Loader keeps 8-bit running sum (mod 256) of all data bytes, excluding the count. After final WRITE go CSUM (in_ready = 1); on transfer go DONE if byte == sum, else ERR. Sum resets to 0 on reset.
- Not defined: no CSUM state, no checksum byte expected, error output constant 0.

## Test plan
- Stream 02, 12 34, AB CD with in_valid held high -> writes 0x1234 @ 0x00 and 0xABCD @ 0x01, one-cycle mem_web low each, done = 1 and core_reset = 0 one cycle after second write.
- Count 00 followed by 512 bytes (word i = {i, ~i}) -> 256 writes, addresses 0x00..0xFF, done only after address 0xFF written.
- Same 2-word stream with in_valid toggled randomly 50% -> identical SRAM writes and values; no byte lost or duplicated; in_ready low during WRITE.
- BOOT_CHECKSUM_EN: 01, 10 20, checksum 30 -> DONE; checksum 31 -> error = 1, core_reset stays 1, in_ready = 0.
- Reset pulsed after 3 data bytes of a 2-word stream, then full stream 01, BE EF -> only 0xBEEF @ 0x00 written post-reset; state restarts at COUNT.
- After done, drive 4 more bytes with in_valid = 1 -> in_ready stays 0, no further SRAM writes, done/core_reset unchanged.

Source files
------------

// File: rtl/boot_loader_if.sv
// Byte-source handshake plus SRAM load port of the boot loader.
// master: byte source side; slave: the loader itself.
interface boot_loader_if;
  logic [0:7]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [0:7]  mem_addr;
  logic [0:15] mem_data;
  logic        mem_csb;
  logic        mem_web;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_addr, mem_data, mem_csb, mem_web
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_addr, mem_data, mem_csb, mem_web
  );
endinterface

// File: rtl/boot_loader.sv
// boot_loader: receives a length-prefixed byte stream, packs byte pairs into
// 16-bit words, writes them to SRAM from address 0, then releases core reset.
// Optional feature macro: BOOT_CHECKSUM_EN (trailing 8-bit sum byte checked
// before release; mismatch parks in ERR with the core held in reset).
module boot_loader (
  input  logic           clock,
  input  logic           reset,
  boot_loader_if.slave   bus,
  output logic           core_reset,
  output logic           done,
  output logic           error
);

  typedef enum logic [2:0] {
    S_COUNT, S_HI, S_LO, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t     state;
  logic [8:0] remaining;   // words still to write; 256 needs the ninth bit
  logic       xfer;

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] sum;
  logic       error_q;
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  // Ready depends on state only, never on in_valid.
  assign bus.in_ready = (state == S_COUNT) || (state == S_HI) ||
                        (state == S_LO)    || (state == S_CSUM);
  assign xfer = bus.in_valid && bus.in_ready;

  // Loader FSM with registered SRAM strobes and status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_COUNT;
      remaining    <= 9'd0;
      bus.mem_addr <= 8'd0;
      bus.mem_data <= 16'd0;
      bus.mem_csb  <= 1'b1;
      bus.mem_web  <= 1'b1;
      core_reset   <= 1'b1;
      done         <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      sum          <= 8'd0;
      error_q      <= 1'b0;
`endif
    end else begin
      case (state)
        S_COUNT: if (xfer) begin
          // Count 0 encodes a full 256-word image.
          remaining    <= (bus.in_data == 8'd0) ? 9'd256 : {1'b0, bus.in_data};
          bus.mem_addr <= 8'd0;
          state        <= S_HI;
        end
        S_HI: if (xfer) begin
          bus.mem_data[0:7] <= bus.in_data;
`ifdef BOOT_CHECKSUM_EN
          sum <= sum + bus.in_data;
`endif
          state <= S_LO;
        end
        S_LO: if (xfer) begin
          bus.mem_data[8:15] <= bus.in_data;
`ifdef BOOT_CHECKSUM_EN
          sum <= sum + bus.in_data;
`endif
          // Strobes are registered so they are low for exactly the WRITE cycle.
          bus.mem_csb <= 1'b0;
          bus.mem_web <= 1'b0;
          state       <= S_WRITE;
        end
        S_WRITE: begin
          bus.mem_csb  <= 1'b1;
          bus.mem_web  <= 1'b1;
          bus.mem_addr <= bus.mem_addr + 8'd1;
          remaining    <= remaining - 9'd1;
          if (remaining == 9'd1) begin
`ifdef BOOT_CHECKSUM_EN
            state <= S_CSUM;
`else
            state      <= S_DONE;
            done       <= 1'b1;
            core_reset <= 1'b0;
`endif
          end else begin
            state <= S_HI;
          end
        end
`ifdef BOOT_CHECKSUM_EN
        S_CSUM: if (xfer) begin
          if (bus.in_data == sum) begin
            state      <= S_DONE;
            done       <= 1'b1;
            core_reset <= 1'b0;
          end else begin
            state   <= S_ERR;
            error_q <= 1'b1;
          end
        end
`endif
        S_DONE, S_ERR: ;  // sticky until reset
        default: state <= S_COUNT;
      endcase
    end
  end

endmodule
